// File: rtl/gb_ext_regfile_pkg.sv
// Shared defaults and reset-value helper for the ghostbus external register file.
package gb_ext_pkg;

    localparam int unsigned DEFAULT_AW     = 4;
    localparam int unsigned DEFAULT_DW     = 8;
    localparam logic [3:0]  RST_NIBBLE     = 4'hb;
    localparam int unsigned RST_WORD_MAX_W = 32;

    // Reset word for index: {index[3:0], RST_NIBBLE}, zero above bit 7, cut to width.
    function automatic logic [RST_WORD_MAX_W-1:0] rst_word(input int unsigned index,
                                                           input int unsigned width);
        logic [RST_WORD_MAX_W-1:0] w;
        logic [3:0]                nib;
        nib    = 4'(index);
        w      = '0;
        w[7:0] = {nib, RST_NIBBLE};
        for (int unsigned b = 0; b < RST_WORD_MAX_W; b++) begin
            if (b >= width) w[b] = 1'b0;
        end
        return w;
    endfunction

endpackage

// File: rtl/gb_ext_regfile_if.sv
// Extmod-style bus between a ghostbus host and the external register file.
interface gb_ext_regfile_if #(
    parameter int aw = gb_ext_pkg::DEFAULT_AW,
    parameter int dw = gb_ext_pkg::DEFAULT_DW
) ();

    logic [aw-1:0] addr;
    logic [dw-1:0] din;
    logic [dw-1:0] dout;
    logic          we;

    modport master (output addr, output din, output we, input  dout);
    modport slave  (input  addr, input  din, input  we, output dout);

endinterface

// File: rtl/gb_ext_regfile_mem_array.sv
// Flop storage array with asynchronous reset-to-pattern and a single write port.
module gb_ext_mem_array
    import gb_ext_pkg::*;
#(
    parameter int aw          = DEFAULT_AW,
    parameter int dw          = DEFAULT_DW,
    parameter int RST_PATTERN = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we_i,
    input  logic [aw-1:0]                addr_i,
    input  logic [dw-1:0]                din_i,
    output logic [(2**aw)-1:0][dw-1:0]   mem_o
);

    localparam int DEPTH = 2 ** aw;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        localparam logic [dw-1:0] RST_VAL = (RST_PATTERN != 0) ? dw'(rst_word(i, dw)) : '0;

        logic [dw-1:0] word_q;

        // Reset dominates, so a write coinciding with rst_n low is dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= RST_VAL;
            end else if (we_i && (addr_i == aw'(i))) begin
                word_q <= din_i;
            end
        end

        assign mem_o[i] = word_q;
    end

endmodule

// File: rtl/gb_ext_regfile.sv
// External register file: 2**aw words of dw bits, synchronous write, registered read.
module gb_ext_regfile
    import gb_ext_pkg::*;
#(
    parameter int aw          = DEFAULT_AW,
    parameter int dw          = DEFAULT_DW,
    parameter int RST_PATTERN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    gb_ext_regfile_if.slave bus
);

    logic [(2**aw)-1:0][dw-1:0] mem;
    logic [dw-1:0]              dout_q;
    logic [dw-1:0]              dout_d;

    gb_ext_mem_array #(
        .aw          (aw),
        .dw          (dw),
        .RST_PATTERN (RST_PATTERN)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (bus.we),
        .addr_i (bus.addr),
        .din_i  (bus.din),
        .mem_o  (mem)
    );

    // Reads the pre-edge array, giving read-before-write on a same-address write.
    always_comb begin
        dout_d = mem[bus.addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;

endmodule

// File: tb/tb_gb_ext_regfile.sv
// Scoreboard bench for gb_ext_regfile: default geometry plus two aw=3/dw=4 variants.
module tb_gb_ext_regfile;

    typedef struct {
        string      name;
        int         addr;
        logic [7:0] val;
    } exp_t;

    typedef struct {
        int         addr;
        logic [3:0] a;
        logic [3:0] b;
    } expv_t;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    exp_t       sb[$];
    expv_t      sbv[$];
    logic [7:0] model[16];
    logic [3:0] va_model[8];
    logic [3:0] vb_model[8];

    gb_ext_regfile_if #(.aw(4), .dw(8)) mbus ();
    gb_ext_regfile_if #(.aw(3), .dw(4)) abus ();
    gb_ext_regfile_if #(.aw(3), .dw(4)) bbus ();

    gb_ext_regfile #(.aw(4), .dw(8), .RST_PATTERN(1)) dut_main (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mbus.slave)
    );

    gb_ext_regfile #(.aw(3), .dw(4), .RST_PATTERN(1)) dut_pat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (abus.slave)
    );

    gb_ext_regfile #(.aw(3), .dw(4), .RST_PATTERN(0)) dut_zero (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bbus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 8'(i * 16 + 11);
        for (int i = 0; i < 8; i++) begin
            va_model[i] = 4'hb;
            vb_model[i] = 4'h0;
        end
    endtask

    // Drives one bus cycle on the main DUT and queues the dout expected after the edge.
    task automatic drive(input int a, input bit w, input logic [7:0] d, input string nm);
        mbus.addr = 4'(a);
        mbus.we   = w;
        mbus.din  = d;
        sb.push_back('{nm, a, model[a]});
        if (w) model[a] = d;
    endtask

    task automatic drive_v(input int a, input bit w, input logic [3:0] d);
        abus.addr = 3'(a);
        bbus.addr = 3'(a);
        abus.we   = w;
        bbus.we   = w;
        abus.din  = d;
        bbus.din  = d;
        sbv.push_back('{a, va_model[a], vb_model[a]});
        if (w) begin
            va_model[a] = d;
            vb_model[a] = d;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n     = 1'b0;
        mbus.we   = 1'b1;
        mbus.addr = 4'd3;
        mbus.din  = 8'hff;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mbus.dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_dout got=%h want=00", mbus.dout);
        end
        checks++;
        if (abus.dout !== 4'h0 || bbus.dout !== 4'h0) begin
            failures++;
            $display("FAIL reset_variant_dout got=%h/%h want=0/0", abus.dout, bbus.dout);
        end
        mbus.we = 1'b0;
        rst_n   = 1'b1;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            drive(i, 1'b0, 8'h00, "reset_contents");
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (mbus.dout !== e.val) begin
                failures++;
                $display("FAIL %s addr=%0d got=%h want=%h", e.name, e.addr, mbus.dout, e.val);
            end
        end
    endtask

    task automatic test_write_readback();
        exp_t e;
        drive(4,  1'b1, 8'h5a, "wr4_old");
        @(posedge clk); #1;
        drive(15, 1'b1, 8'ha5, "wr15_old");
        @(posedge clk); #1;
        drive(4,  1'b0, 8'h00, "rd4");
        @(posedge clk); #1;
        drive(15, 1'b0, 8'h00, "rd15");
        @(posedge clk); #1;
        drive(5,  1'b0, 8'h00, "rd5_untouched");
        @(posedge clk); #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (e.name == "rd5_untouched" && e.val !== 8'h5b) begin
                failures++;
                $display("FAIL model_rd5 got=%h want=5b", e.val);
            end
        end
        checks++;
        if (mbus.dout !== 8'h5b) begin
            failures++;
            $display("FAIL rd5_untouched got=%h want=5b", mbus.dout);
        end
        drive(4, 1'b0, 8'h00, "rd4_again");
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (mbus.dout !== e.val || e.val !== 8'h5a) begin
            failures++;
            $display("FAIL %s got=%h want=5a", e.name, mbus.dout);
        end
        drive(15, 1'b0, 8'h00, "rd15_again");
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (mbus.dout !== e.val || e.val !== 8'ha5) begin
            failures++;
            $display("FAIL %s got=%h want=a5", e.name, mbus.dout);
        end
    endtask

    task automatic test_read_before_write();
        exp_t e;
        drive(2, 1'b1, 8'hc3, "rbw_old");
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (mbus.dout !== e.val || mbus.dout !== 8'h2b) begin
            failures++;
            $display("FAIL %s got=%h want=2b", e.name, mbus.dout);
        end
        drive(2, 1'b0, 8'h00, "rbw_new");
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (mbus.dout !== e.val || mbus.dout !== 8'hc3) begin
            failures++;
            $display("FAIL %s got=%h want=c3", e.name, mbus.dout);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(7, 1'b1, 8'h77, "ar_write");
        @(posedge clk); #1;
        void'(sb.pop_front());
        drive(7, 1'b0, 8'h00, "ar_read77");
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (mbus.dout !== e.val) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.name, mbus.dout, e.val);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mbus.dout !== 8'h00) begin
            failures++;
            $display("FAIL async_dout_clear got=%h want=00", mbus.dout);
        end
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        drive(7, 1'b0, 8'h00, "ar_read7b");
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (mbus.dout !== e.val || mbus.dout !== 8'h7b) begin
            failures++;
            $display("FAIL %s got=%h want=7b", e.name, mbus.dout);
        end
    endtask

    task automatic test_variants();
        expv_t e;
        for (int i = 0; i < 8; i++) begin
            drive_v(i, 1'b0, 4'h0);
            @(posedge clk); #1;
            e = sbv.pop_front();
            checks++;
            if (abus.dout !== e.a || bbus.dout !== e.b) begin
                failures++;
                $display("FAIL variant_reset addr=%0d got=%h/%h want=%h/%h",
                         e.addr, abus.dout, bbus.dout, e.a, e.b);
            end
        end
        drive_v(7, 1'b1, 4'h9);
        @(posedge clk); #1;
        void'(sbv.pop_front());
        drive_v(7, 1'b0, 4'h0);
        @(posedge clk); #1;
        e = sbv.pop_front();
        checks++;
        if (abus.dout !== 4'h9 || bbus.dout !== 4'h9 || e.a !== 4'h9) begin
            failures++;
            $display("FAIL variant_rd7 got=%h/%h want=9/9", abus.dout, bbus.dout);
        end
        abus.we = 1'b0;
        bbus.we = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            drive(i, 1'b1, 8'(i) ^ 8'hff, "b2b_write");
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (mbus.dout !== e.val) begin
                failures++;
                $display("FAIL %s addr=%0d got=%h want=%h", e.name, e.addr, mbus.dout, e.val);
            end
        end
        for (int i = 0; i < 16; i++) begin
            drive(i, 1'b0, 8'h00, "b2b_read");
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (mbus.dout !== e.val || e.val !== (8'(i) ^ 8'hff)) begin
                failures++;
                $display("FAIL %s addr=%0d got=%h want=%h", e.name, e.addr, mbus.dout,
                         8'(i) ^ 8'hff);
            end
        end
        mbus.we = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        mbus.addr = '0;
        mbus.din  = '0;
        mbus.we   = 1'b0;
        abus.addr = '0;
        abus.din  = '0;
        abus.we   = 1'b0;
        bbus.addr = '0;
        bbus.din  = '0;
        bbus.we   = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_write_readback();
        test_read_before_write();
        test_async_reset();
        test_variants();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
